// File: rtl/event_demux_pkg.sv
// Shared constants and types for the event demultiplexer and its per-sink slots.
package event_demux_pkg;

    localparam int SELW = 3;

    typedef logic [7:0]  drop_cnt_t;
    typedef logic [15:0] xfer_cnt_t;

    localparam drop_cnt_t DROP_MAX = 8'hFF;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot for a single sink; a load on the draining edge
// replaces the entry without a bubble.
//
// state      | meaning
// SLOT_EMPTY | no event held, valid low
// SLOT_FULL  | event held in data_q, valid high until ready
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data_out
);
    import event_demux_pkg::*;

    slot_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = SLOT_FULL;
            data_d  = data_in;
        end else if (state_q == SLOT_FULL && ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    assign valid    = (state_q == SLOT_FULL);
    assign data_out = data_q;

endmodule

// File: rtl/event_demux.sv
// Routes source events to one of N_OUT one-entry sink slots by in_sel;
// illegal selects are swallowed and counted.
module event_demux #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SELW  = event_demux_pkg::SELW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SELW-1:0]        in_sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [7:0]             drop_cnt,
    output logic [15:0]            xfer_cnt
);
    import event_demux_pkg::*;

    logic [N_OUT-1:0] slot_valid;
    logic [N_OUT-1:0] slot_load;
    logic             sel_legal;
    logic             sel_ready;
    logic             accept;
    drop_cnt_t        drop_q, drop_d;
    xfer_cnt_t        xfer_q, xfer_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
            xfer_q <= '0;
        end else begin
            drop_q <= drop_d;
            xfer_q <= xfer_d;
        end
    end

    // Extra select bit so N_OUT = 8 still compares correctly.
    always_comb begin
        sel_legal = ({1'b0, in_sel} < (SELW+1)'(N_OUT));
        sel_ready = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (in_sel == SELW'(i)) sel_ready = !slot_valid[i] || out_ready[i];
        end
        in_ready  = !reset && (sel_legal ? sel_ready : 1'b1);
        accept    = in_valid && in_ready;
        slot_load = '0;
        for (int i = 0; i < N_OUT; i++) begin
            slot_load[i] = accept && sel_legal && (in_sel == SELW'(i));
        end
        drop_d = drop_q;
        if (accept && !sel_legal && drop_q != DROP_MAX) drop_d = drop_q + 8'd1;
        xfer_d = xfer_q;
        if (accept && sel_legal) xfer_d = xfer_q + 16'd1;
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (slot_load[g]),
            .data_in  (in_data),
            .ready    (out_ready[g]),
            .valid    (slot_valid[g]),
            .data_out (out_data[g*WIDTH +: WIDTH])
        );
    end

    assign out_valid = slot_valid;
    assign drop_cnt  = drop_q;
    assign xfer_cnt  = xfer_q;

endmodule

// File: tb/tb_event_demux.sv
// Directed bench for event_demux: a 4-sink instance for the main scenarios
// and a 3-sink instance for illegal-select handling.
module tb_event_demux;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [7:0]  drop_cnt;
    logic [15:0] xfer_cnt;

    logic        in3_valid;
    logic        in3_ready;
    logic [7:0]  in3_data;
    logic [2:0]  in3_sel;
    logic [2:0]  out3_valid;
    logic [2:0]  out3_ready;
    logic [23:0] out3_data;
    logic [7:0]  drop3_cnt;
    logic [15:0] xfer3_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    event_demux #(.WIDTH(8), .N_OUT(4), .SELW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt),
        .xfer_cnt  (xfer_cnt)
    );

    event_demux #(.WIDTH(8), .N_OUT(3), .SELW(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in3_valid),
        .in_ready  (in3_ready),
        .in_data   (in3_data),
        .in_sel    (in3_sel),
        .out_valid (out3_valid),
        .out_ready (out3_ready),
        .out_data  (out3_data),
        .drop_cnt  (drop3_cnt),
        .xfer_cnt  (xfer3_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int ov3_seen;
        int rdy3_low;

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sel     = '0;
        out_ready  = '0;
        in3_valid  = 1'b0;
        in3_data   = '0;
        in3_sel    = '0;
        out3_ready = '0;

        #2;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_drop", 32'(drop_cnt), 32'h0);
        check("rst_xfer", 32'(xfer_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // single event to sink 2
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_sel    = 3'd2;
        in_data   = 8'hA5;
        #1;
        check("single_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check("single_out_valid", 32'(out_valid), 32'h4);
        check("single_data", 32'(out_data[23:16]), 32'hA5);
        check("single_xfer", 32'(xfer_cnt), 32'h1);
        tick();
        check("single_drained", 32'(out_valid), 32'h0);

        // backpressure on sink 1
        out_ready = 4'b1101;
        in_valid  = 1'b1;
        in_sel    = 3'd1;
        in_data   = 8'h11;
        #1;
        check("bp_first_ready", 32'(in_ready), 32'h1);
        tick();
        in_data = 8'h22;
        #1;
        check("bp_second_blocked", 32'(in_ready), 32'h0);
        tick();
        check("bp_still_blocked", 32'(in_ready), 32'h0);
        check("bp_hold_valid", 32'(out_valid), 32'h2);
        check("bp_hold_data", 32'(out_data[15:8]), 32'h11);
        check("bp_xfer_hold", 32'(xfer_cnt), 32'h2);
        out_ready[1] = 1'b1;
        #1;
        check("bp_ready_comb", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check("bp_second_valid", 32'(out_valid), 32'h2);
        check("bp_second_data", 32'(out_data[15:8]), 32'h22);
        tick();
        check("bp_drained", 32'(out_valid), 32'h0);
        check("bp_xfer", 32'(xfer_cnt), 32'h3);

        // full throughput on sink 0
        pulse_reset();
        out_ready = 4'hF;
        in_sel    = 3'd0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h30 + 8'(k);
            #1;
            check($sformatf("tput_ready_%0d", k), 32'(in_ready), 32'h1);
            tick();
            check($sformatf("tput_valid_%0d", k), 32'(out_valid), 32'h1);
            check($sformatf("tput_data_%0d", k), 32'(out_data[7:0]), 32'h30 + k);
        end
        in_valid = 1'b0;
        check("tput_xfer", 32'(xfer_cnt), 32'd10);
        tick();
        check("tput_drained", 32'(out_valid), 32'h0);

        // fill all slots, drain together, refill, then reset mid-operation
        out_ready = 4'h0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sel   = 3'(k);
            in_data  = 8'h40 + 8'(k);
            tick();
        end
        in_valid = 1'b0;
        check("fill_valid", 32'(out_valid), 32'hF);
        check("fill_data", out_data, 32'h43424140);
        out_ready = 4'hF;
        tick();
        check("drain_all", 32'(out_valid), 32'h0);
        out_ready = 4'h0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sel   = 3'(k);
            in_data  = 8'h50 + 8'(k);
            tick();
        end
        check("refill_valid", 32'(out_valid), 32'hF);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_data", out_data, 32'h0);
        check("mid_rst_ready", 32'(in_ready), 32'h0);
        check("mid_rst_xfer", 32'(xfer_cnt), 32'h0);
        check("mid_rst_drop", 32'(drop_cnt), 32'h0);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("post_rst_valid", 32'(out_valid), 32'h0);

        // illegal selects on the 3-sink instance
        out3_ready = 3'h7;
        in3_valid  = 1'b1;
        in3_sel    = 3'd3;
        in3_data   = 8'hEE;
        #1;
        check("ill_sel3_ready", 32'(in3_ready), 32'h1);
        tick();
        check("ill_sel3_drop", 32'(drop3_cnt), 32'h1);
        check("ill_sel3_valid", 32'(out3_valid), 32'h0);
        in3_sel  = 3'd5;
        ov3_seen = 0;
        rdy3_low = 0;
        for (int k = 0; k < 300; k++) begin
            in3_data = 8'(k);
            #1;
            if (!in3_ready) rdy3_low++;
            tick();
            if (out3_valid != 3'h0) ov3_seen++;
            if (k == 200) check("ill_drop_mid", 32'(drop3_cnt), 32'd202);
        end
        in3_valid = 1'b0;
        check("ill_ready_low_cycles", 32'(rdy3_low), 32'h0);
        check("ill_out_valid_seen", 32'(ov3_seen), 32'h0);
        check("ill_drop_sat", 32'(drop3_cnt), 32'd255);
        check("ill_xfer", 32'(xfer3_cnt), 32'h0);
        in3_valid = 1'b1;
        in3_sel   = 3'd2;
        in3_data  = 8'h77;
        tick();
        in3_valid = 1'b0;
        check("n3_legal_valid", 32'(out3_valid), 32'h4);
        check("n3_legal_data", 32'(out3_data[23:16]), 32'h77);
        check("n3_legal_xfer", 32'(xfer3_cnt), 32'h1);
        check("n3_drop_unchanged", 32'(drop3_cnt), 32'd255);

        // transfer counter wrap
        pulse_reset();
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_sel    = 3'd3;
        for (int k = 0; k < 65535; k++) begin
            in_data = 8'(k);
            tick();
        end
        check("wrap_preload", 32'(xfer_cnt), 32'hFFFF);
        tick();
        in_valid = 1'b0;
        check("wrap_zero", 32'(xfer_cnt), 32'h0);
        check("wrap_drop", 32'(drop_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
